mc_control: RTL
===============

# mc_control

Multicycle control unit for the MIPS core. Sequences the shared fetch/decode/execute datapath one instruction at a time: it drives the register-file write port (`regWrite`/`regDst`/`memToReg`) consumed by `decode`, the PC/IR enables, ALU operand muxes and the memory strobes. It sits beside the datapath top and is the only source of these control signals.

## Interface
Parameters
- `CNT_W`, 32: width of the retired-instruction counter.

Ports
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  `instruction[31:26]`, valid from DECODE onward.
- `memReady`  in  1  memory access complete this cycle.
- `pcWrite`, `pcWriteCond`, `irWrite`, `memRead`, `memWrite`, `regWrite`  out  1 each  datapath strobes.
- `iorD`, `memToReg`, `regDst`, `aluSrcA`  out  1 each  mux selects.
- `aluSrcB`, `aluOp`, `pcSource`  out  2 each  mux selects / ALU class.
- `state`  out  4  current state encoding (debug).
- `illegal`  out  1  one-cycle pulse on unsupported opcode.
- `instCount`  out  `CNT_W`  instructions retired since reset.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- Outputs are a decode of `state` (plus `memReady` gating below); unlisted signals are 0.
- FETCH: memRead=1, aluSrcB=01, pcSource=00; irWrite=pcWrite=memReady. Exit to DECODE when memReady, else hold.
- DECODE: aluSrcB=11 (branch target precompute). Next by opcode: 100011/101011 → MEMADR; 000000 → EXEC; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDIEX; other → FETCH with `illegal`=1.
- MEMADR: aluSrcA=1, aluSrcB=10 → MEMRD (lw) or MEMWR (sw).
- MEMRD: memRead=1, iorD=1; hold until memReady, then MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0 → FETCH.
- MEMWR: memWrite=1, iorD=1; hold until memReady, then FETCH.
- EXEC: aluSrcA=1, aluOp=10 → ALUWB. ALUWB: regWrite=1, regDst=1 → FETCH.
- BRANCH: aluSrcA=1, aluOp=01, pcWriteCond=1, pcSource=01 → FETCH.
- JUMP: pcWrite=1, pcSource=10 → FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00 → ADDIWB. ADDIWB: regWrite=1, regDst=0 → FETCH.
- `instCount` increments by 1 on every transition into FETCH from a state other than FETCH, excluding illegal-opcode exits; wraps modulo 2^CNT_W.

## Timing
- Reset: `state`=FETCH, `instCount`=0, `illegal`=0; while `rst`=1 all strobes (pcWrite, pcWriteCond, irWrite, memWrite, regWrite) forced 0 regardless of state; selects follow FETCH decode.
- `rst` asserted mid-instruction aborts it: next edge FETCH, no count increment, no write strobe in that cycle.
- Cycles per instruction with memReady tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each memReady-0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle; strobes other than memRead/memWrite stay stable while stalled.
- memReady outside FETCH/MEMRD/MEMWR is ignored.

## Configuration
- `MC_CTRL_ADDI_EN` defined: ADDIEX/ADDIWB implemented as above.
- Undefined: opcode 001000 treated as illegal (pulse `illegal`, return to FETCH); encodings 10–11 unreachable; all other behaviour identical.

## Structure
- Shared package `mips_pkg`: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), state enum/encodings, aluOp/pcSource/aluSrcB codes.
- Single module; no sub-module needed. State register + next-state logic + output decode + counter.

## Test plan
- Reset then opcode 000000, memReady=1 → states 0,1,6,7,0; regWrite=1 and regDst=1 only in ALUWB; instCount=1.
- lw (100011) with memReady low 2 cycles in MEMRD → lw takes 7 cycles; memToReg=1 regWrite=1 in MEMWB only.
- sw (101011) → memWrite=1, iorD=1 in MEMWR; no regWrite anywhere; 4 cycles.
- beq then j → pcWriteCond=1 pcSource=01 in BRANCH; pcWrite=1 pcSource=10 in JUMP; instCount +2.
- Opcode 111111 → `illegal` pulse in DECODE, back to FETCH, instCount unchanged; with macro undefined same for 001000, defined → addi 4 cycles.
- `rst`=1 during MEMWB → no regWrite that cycle, state=FETCH, instCount=0 next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, control-FSM state encodings, mux/ALU codes
// and the packed control-strobe bundle driven by mc_control.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       iorD;
    logic       memToReg;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
  } ctrl_t;

endpackage

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: state register, next-state, output decode and
// retired-instruction counter. MC_CTRL_ADDI_EN enables the addi path.
module mc_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             irWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             regWrite,
  output logic             iorD,
  output logic             memToReg,
  output logic             regDst,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       pcSource,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instCount
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_op;
  logic             retire;
  ctrl_t            c;

  always_comb begin
    state_d = state_q;
    bad_op  = 1'b0;
    case (state_q)
      S_FETCH:  if (memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default: begin
            state_d = S_FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (memReady) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (memReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Illegal-opcode exits land in FETCH without retiring anything.
  assign retire = (state_q != S_FETCH) && (state_d == S_FETCH) && !bad_op;
  assign cnt_d  = cnt_q + CNT_W'(retire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Under reset the selects decode as FETCH and every write strobe is masked.
  always_comb begin
    c = '0;
    case (rst ? S_FETCH : state_q)
      S_FETCH: begin
        c.memRead = 1'b1;
        c.aluSrcB = SRCB_FOUR;
        c.pcSource = PCSRC_ALU;
        c.irWrite = memReady;
        c.pcWrite = memReady;
      end
      S_DECODE: c.aluSrcB = SRCB_BRANCH;
      S_MEMADR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
      end
      S_MEMWB: begin
        c.regWrite = 1'b1;
        c.memToReg = 1'b1;
      end
      S_MEMWR: begin
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
      end
      S_EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
      end
      S_BRANCH: begin
        c.aluSrcA     = 1'b1;
        c.aluOp       = ALUOP_SUB;
        c.pcWriteCond = 1'b1;
        c.pcSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pcWrite  = 1'b1;
        c.pcSource = PCSRC_JUMP;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALUOP_ADD;
      end
      S_ADDIWB: c.regWrite = 1'b1;
`endif
      default: c = '0;
    endcase
    if (rst) begin
      c.pcWrite     = 1'b0;
      c.pcWriteCond = 1'b0;
      c.irWrite     = 1'b0;
      c.memWrite    = 1'b0;
      c.regWrite    = 1'b0;
    end
  end

  assign pcWrite     = c.pcWrite;
  assign pcWriteCond = c.pcWriteCond;
  assign irWrite     = c.irWrite;
  assign memRead     = c.memRead;
  assign memWrite    = c.memWrite;
  assign regWrite    = c.regWrite;
  assign iorD        = c.iorD;
  assign memToReg    = c.memToReg;
  assign regDst      = c.regDst;
  assign aluSrcA     = c.aluSrcA;
  assign aluSrcB     = c.aluSrcB;
  assign aluOp       = c.aluOp;
  assign pcSource    = c.pcSource;
  assign state       = state_q;
  assign illegal     = bad_op & ~rst;
  assign instCount   = cnt_q;

endmodule
